// File: rtl/iir_sink_buffer_pkg.sv
// Shared definitions for the filter output sink buffer.
//   NB_DEF     : default sample width (matches the filter DOUT)
//   CW_DEF     : default width of the statistics counters
//   sample_t   : two's complement sample at the default width
//   SAMPLE_MAX : positive full scale, 0x0FFF
//   SAMPLE_MIN : negative full scale, 0x1000
package iir_sink_buffer_pkg;

  localparam int NB_DEF = 13;
  localparam int CW_DEF = 16;

  typedef logic signed [NB_DEF-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = 13'sh0FFF;
  localparam sample_t SAMPLE_MIN = 13'sh1000;

endpackage

// File: rtl/sink_fifo_mem.sv
// Sample storage for the sink buffer: DEPTH x NB register array with one
// write port and one registered read port.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (clears the read register only)
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable, loads rdata on the edge
//   raddr : read address
//   rdata : registered read data, holds when re=0
module sink_fifo_mem
  import iir_sink_buffer_pkg::*;
#(
  parameter int NB    = NB_DEF,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [NB-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [NB-1:0] rdata
);

  logic signed [NB-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read stage: the read sees the array before this edge's write, so a
  // read and a write to the same slot (full buffer) returns the old sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/iir_sink_buffer.sv
// Receive end of the IIR filter output stream. Each valid sample is pushed
// into a FIFO and handed to a consumer through a read handshake; saturating
// statistics count offered samples and accepted full-scale (clipped) samples,
// and a sticky flag records any drop caused by a full buffer.
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset
//   VIN, DIN   : input sample valid / sample (from filter VOUT / DOUT)
//   RD_EN      : read request from the consumer
//   DOUT, VOUT : registered read data / one-cycle valid pulse
//   FULL       : DEPTH entries stored
//   EMPTY      : no entries stored
//   LEVEL      : occupancy 0..DEPTH
//   OVF        : sticky, a sample was dropped
//   SAMPLE_CNT : saturating count of VIN pulses
//   CLIP_CNT   : saturating count of accepted full-scale samples
module iir_sink_buffer
  import iir_sink_buffer_pkg::*;
#(
  parameter int NB    = NB_DEF,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CW    = CW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          VIN,
  input  logic [NB-1:0] DIN,
  input  logic          RD_EN,
  output logic [NB-1:0] DOUT,
  output logic          VOUT,
  output logic          FULL,
  output logic          EMPTY,
  output logic [AW:0]   LEVEL,
  output logic          OVF,
  output logic [CW-1:0] SAMPLE_CNT,
  output logic [CW-1:0] CLIP_CNT
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic signed [NB-1:0] FS_MAX = {1'b0, {(NB-1){1'b1}}};
  localparam logic signed [NB-1:0] FS_MIN = {1'b1, {(NB-1){1'b0}}};

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  function automatic logic is_full_scale(input logic signed [NB-1:0] s);
    return (s == FS_MAX) || (s == FS_MIN);
  endfunction

  logic signed [NB-1:0] din_p0;
  logic                 vld_p0;
  logic signed [NB-1:0] dout_p1;
  logic                 vld_p1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_r;
  logic [AW:0]   level_nxt;
  logic          full_r;
  logic          empty_r;
  logic          ovf_r;
  logic [CW-1:0] sample_cnt_r;
  logic [CW-1:0] clip_cnt_r;

  logic rd_acc;
  logic wr_acc;
  logic drop;

  // Input stage: decide accept/drop for this cycle
  assign din_p0 = DIN;
  assign vld_p0 = VIN;

  assign rd_acc = RD_EN && !empty_r;
  // A read in the same cycle frees a slot, so a full buffer still accepts.
  assign wr_acc = vld_p0 && (!full_r || rd_acc);
  assign drop   = vld_p0 && !wr_acc;

  always_comb begin
    level_nxt = level_r;
    case ({wr_acc, rd_acc})
      2'b10:   level_nxt = level_r + (AW+1)'(1);
      2'b01:   level_nxt = level_r - (AW+1)'(1);
      default: level_nxt = level_r;
    endcase
  end

  sink_fifo_mem #(
    .NB    (NB),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (CLK),
    .rst   (RST),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din_p0),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (dout_p1)
  );

  // Output stage: pointers, flags, statistics and read valid
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_r      <= '0;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      vld_p1       <= 1'b0;
      ovf_r        <= 1'b0;
      sample_cnt_r <= '0;
      clip_cnt_r   <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Flags come from the occupancy count, never from pointer equality,
      // so full and empty stay distinguishable after wrap-around.
      level_r <= level_nxt;
      full_r  <= (level_nxt == DEPTH_L);
      empty_r <= (level_nxt == '0);
      vld_p1  <= rd_acc;
      if (drop) begin
        ovf_r <= 1'b1;
      end
      if (vld_p0) begin
        sample_cnt_r <= sat_inc(sample_cnt_r);
      end
      if (wr_acc && is_full_scale(din_p0)) begin
        clip_cnt_r <= sat_inc(clip_cnt_r);
      end
    end
  end

  assign DOUT       = dout_p1;
  assign VOUT       = vld_p1;
  assign FULL       = full_r;
  assign EMPTY      = empty_r;
  assign LEVEL      = level_r;
  assign OVF        = ovf_r;
  assign SAMPLE_CNT = sample_cnt_r;
  assign CLIP_CNT   = clip_cnt_r;

endmodule

// File: tb/tb_iir_sink_buffer.sv
// Self-checking bench for iir_sink_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_iir_sink_buffer;

  localparam int NB    = 13;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          RST;
  logic          VIN;
  logic [NB-1:0] DIN;
  logic          RD_EN;
  logic [NB-1:0] DOUT;
  logic          VOUT;
  logic          FULL;
  logic          EMPTY;
  logic [AW:0]   LEVEL;
  logic          OVF;
  logic [CW-1:0] SAMPLE_CNT;
  logic [CW-1:0] CLIP_CNT;

  iir_sink_buffer #(
    .NB    (NB),
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (CW)
  ) dut (
    .CLK        (clk),
    .RST        (RST),
    .VIN        (VIN),
    .DIN        (DIN),
    .RD_EN      (RD_EN),
    .DOUT       (DOUT),
    .VOUT       (VOUT),
    .FULL       (FULL),
    .EMPTY      (EMPTY),
    .LEVEL      (LEVEL),
    .OVF        (OVF),
    .SAMPLE_CNT (SAMPLE_CNT),
    .CLIP_CNT   (CLIP_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [NB-1:0] q[$];
  logic [NB-1:0] m_dout;
  logic          m_vout;
  logic          m_ovf;
  int            m_scnt;
  int            m_ccnt;

  int n_vec;
  int n_err;
  int n_step;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", tag, n_step, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [NB-1:0] d,
                            input logic re);
    logic rd_ok;
    logic wr_ok;
    if (r) begin
      q.delete();
      m_dout = '0;
      m_vout = 1'b0;
      m_ovf  = 1'b0;
      m_scnt = 0;
      m_ccnt = 0;
    end else begin
      rd_ok  = re && (q.size() > 0);
      wr_ok  = v && ((q.size() < DEPTH) || rd_ok);
      m_vout = rd_ok;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) begin
        q.push_back(d);
        if ((d == 13'h0FFF || d == 13'h1000) && m_ccnt < CMAX) m_ccnt++;
      end
      if (v && !wr_ok) m_ovf = 1'b1;
      if (v && m_scnt < CMAX) m_scnt++;
    end
  endtask

  task automatic check_all();
    chk("DOUT",       32'(DOUT),       32'(m_dout));
    chk("VOUT",       32'(VOUT),       32'(m_vout));
    chk("LEVEL",      32'(LEVEL),      32'(q.size()));
    chk("FULL",       32'(FULL),       32'(q.size() == DEPTH));
    chk("EMPTY",      32'(EMPTY),      32'(q.size() == 0));
    chk("OVF",        32'(OVF),        32'(m_ovf));
    chk("SAMPLE_CNT", 32'(SAMPLE_CNT), 32'(m_scnt));
    chk("CLIP_CNT",   32'(CLIP_CNT),   32'(m_ccnt));
  endtask

  task automatic step(input logic r, input logic v, input logic [NB-1:0] d, input logic re);
    RST   = r;
    VIN   = v;
    DIN   = d;
    RD_EN = re;
    @(posedge clk);
    model_edge(r, v, d, re);
    n_step++;
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic          r;
    logic          v;
    logic          re;
    logic [NB-1:0] d;
    int            rd_bias;
    int            wr_bias;

    n_vec  = 0;
    n_err  = 0;
    n_step = 0;
    m_dout = '0;
    m_vout = 1'b0;
    m_ovf  = 1'b0;
    m_scnt = 0;
    m_ccnt = 0;
    RST = 1'b1; VIN = 1'b0; DIN = '0; RD_EN = 1'b0;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Three writes then three reads
    step(0, 1, 13'h0001, 0);
    step(0, 1, 13'h1FFF, 0);
    step(0, 1, 13'h0ABC, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Fill, overflow on the 17th, drain
    step(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 13'(i * 37 + 5), 0);
    step(0, 1, 13'h0055, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1);

    // Simultaneous read and write while full
    step(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 13'(i * 101 + 3), 0);
    step(0, 1, 13'h0777, 1);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1);

    // Read requests while empty, then write followed by read
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    step(0, 1, 13'h0321, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Full-scale detection, then the same stream dropped while full
    step(0, 1, 13'h0FFF, 0);
    step(0, 1, 13'h1000, 0);
    step(0, 1, 13'h0FFE, 0);
    step(0, 1, 13'h1001, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 13'h0010, 0);
    step(0, 1, 13'h0FFF, 0);
    step(0, 1, 13'h1000, 0);
    step(0, 1, 13'h0FFE, 0);
    step(0, 1, 13'h1001, 0);

    // Reset mid-stream
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 13'(i + 200), 0);
    step(1, 0, 0, 0);
    step(0, 1, 13'h0123, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Randomized traffic with shifting read/write pressure
    rd_bias = 50;
    wr_bias = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        rd_bias = $urandom_range(10, 90);
        wr_bias = $urandom_range(10, 90);
      end
      r  = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 99) < wr_bias);
      re = ($urandom_range(0, 99) < rd_bias);
      case ($urandom_range(0, 7))
        0:       d = 13'h0FFF;
        1:       d = 13'h1000;
        default: d = 13'($urandom);
      endcase
      step(r, v, d, re);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
